dbg_uart_txq: RTL and testbench

//  Downstream sink for the debug bus-snoop packetizers: buffers their byte stream in a FIFO and serializes it as 8N1 UART on one pin.

---
 rtl/dbg_pkg.sv | 17 +
 rtl/dbg_uart_txq_if.sv | 18 +
 rtl/dbg_byte_fifo.sv | 49 ++++
 rtl/dbg_uart_txq.sv | 155 +++++++++++++++
 tb/tb_dbg_uart_txq.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug UART transmit queue: tx FSM encoding and line constants.
package dbg_pkg;
    localparam int   DBG_DATA_W = 8;
    localparam logic UART_IDLE  = 1'b1;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t S_IDLE   = 3'd0;
    localparam tx_state_t S_START  = 3'd1;
    localparam tx_state_t S_DATA   = 3'd2;
    localparam tx_state_t S_PARITY = 3'd3;
    localparam tx_state_t S_STOP   = 3'd4;

    function automatic logic even_par(input logic [DBG_DATA_W-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/dbg_uart_txq_if.sv
// Byte-stream port between the bus-snoop packetizer (master) and the UART tx queue (slave).
interface dbg_uart_txq_if
    import dbg_pkg::*;
#(
    parameter int FIFO_AW = 4
);
    logic [DBG_DATA_W-1:0] data;
    logic                  wr;
    logic                  flush;
    logic                  ovf_clr;
    logic                  full;
    logic [FIFO_AW:0]      level;
    logic                  txe;
    logic                  ovf;

    modport master (output data, wr, flush, ovf_clr, input full, level, txe, ovf);
    modport slave  (input data, wr, flush, ovf_clr, output full, level, txe, ovf);
endinterface

// File: rtl/dbg_byte_fifo.sv
// Byte FIFO with wrap-bit pointers, flush, and a registered head that already reflects a same-cycle write.
module dbg_byte_fifo
    import dbg_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic                  clk_asic,
    input  logic                  rst_n,
    input  logic [DBG_DATA_W-1:0] din,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DBG_DATA_W-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_AW:0]      level
);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DBG_DATA_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0]      wr_ptr, rd_ptr, rd_nx;
    logic                  push_ok, pop_ok, bypass;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_nx   = flush ? wr_ptr : rd_ptr + {{FIFO_AW{1'b0}}, pop_ok};
    // the slot the head will point at may be the one being written right now
    assign bypass  = push_ok && (wr_ptr[FIFO_AW-1:0] == rd_nx[FIFO_AW-1:0]);

    always_ff @(posedge clk_asic) begin
        if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

    always_ff @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, push_ok};
            rd_ptr <= rd_nx;
            head   <= bypass ? din : mem[rd_nx[FIFO_AW-1:0]];
        end
    end
endmodule

// File: rtl/dbg_uart_txq.sv
// Queued debug UART transmitter, 8N1 by default; define DBG_UART_PARITY_EN for 8E1 frames.
//  state    | meaning
//  IDLE     | line high, waiting for a queued byte
//  START    | start bit (low)
//  DATA     | 8 data bits, LSB first
//  PARITY   | even parity bit (DBG_UART_PARITY_EN only)
//  STOP     | stop bit (high); chains straight into the next frame if data is queued
module dbg_uart_txq
    import dbg_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int FIFO_AW = 4
) (
    input  logic          clk_asic,
    input  logic          rst_n,
    dbg_uart_txq_if.slave bus,
    output logic          tx
);
    localparam int                CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  BAUD_LOAD = CNT_W'(CLK_DIV - 1);
    localparam int                BIT_W     = $clog2(DBG_DATA_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBG_DATA_W - 1);

    tx_state_t             state, state_n;
    logic [CNT_W-1:0]      baud_cnt, baud_n;
    logic [BIT_W-1:0]      bit_idx, bit_n;
    logic [DBG_DATA_W-1:0] shreg, shreg_n, head;
    logic [FIFO_AW:0]      level;
    logic                  push, drop, pop, fifo_full, fifo_empty, fifo_empty_nx;
    logic                  tx_n, txe_n, txe_q, ovf_q;
`ifdef DBG_UART_PARITY_EN
    logic                  par_q, par_n;
`endif

    assign push = bus.wr & ~fifo_full;
    assign drop = bus.wr & fifo_full;

    dbg_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk_asic (clk_asic),
        .rst_n    (rst_n),
        .din      (bus.data),
        .push     (push),
        .pop      (pop),
        .flush    (bus.flush),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign bus.full  = fifo_full;
    assign bus.level = level;
    assign bus.txe   = txe_q;
    assign bus.ovf   = ovf_q;
    assign fifo_empty_nx = bus.flush | fifo_empty | ((level == (FIFO_AW+1)'(1)) & pop);

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        pop     = 1'b0;
`ifdef DBG_UART_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            S_IDLE:  pop = ~fifo_empty;
            S_START: begin
                if (baud_cnt == '0) begin
                    state_n = S_DATA;
                    baud_n  = BAUD_LOAD;
                    bit_n   = '0;
                end else baud_n = baud_cnt - CNT_W'(1);
            end
            S_DATA: begin
                if (baud_cnt == '0) begin
                    baud_n = BAUD_LOAD;
                    if (bit_idx == BIT_LAST) begin
`ifdef DBG_UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n   = bit_idx + BIT_W'(1);
                        shreg_n = shreg >> 1;
                    end
                end else baud_n = baud_cnt - CNT_W'(1);
            end
`ifdef DBG_UART_PARITY_EN
            S_PARITY: begin
                if (baud_cnt == '0) begin
                    state_n = S_STOP;
                    baud_n  = BAUD_LOAD;
                end else baud_n = baud_cnt - CNT_W'(1);
            end
`endif
            S_STOP: begin
                if (baud_cnt == '0) begin
                    if (!fifo_empty) pop = 1'b1;
                    else state_n = S_IDLE;
                end else baud_n = baud_cnt - CNT_W'(1);
            end
            default: state_n = S_IDLE;
        endcase
        if (pop) begin
            state_n = S_START;
            baud_n  = BAUD_LOAD;
            shreg_n = head;
`ifdef DBG_UART_PARITY_EN
            par_n   = even_par(head);
`endif
        end
    end

    // tx and txe are decoded from next-state values so both leave flops glitch-free
    always_comb begin
        case (state_n)
            S_START:  tx_n = ~UART_IDLE;
            S_DATA:   tx_n = shreg_n[0];
`ifdef DBG_UART_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = UART_IDLE;
        endcase
        txe_n = (state_n == S_IDLE) & fifo_empty_nx & ~push;
    end

    always_ff @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= UART_IDLE;
            txe_q    <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef DBG_UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            txe_q    <= txe_n;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
`ifdef DBG_UART_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_dbg_uart_txq.sv
// Bench for dbg_uart_txq: vector table, hand sequences and random traffic against a frame-level queue model.
module tb_dbg_uart_txq;
    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 2 ** FIFO_AW;
`ifdef DBG_UART_PARITY_EN
    localparam int NBITS   = 11;
`else
    localparam int NBITS   = 10;
`endif
    localparam int FRAME   = NBITS * CLK_DIV;

    logic clk_asic = 1'b0;
    logic rst_n    = 1'b0;
    logic tx;

    always #5 clk_asic = ~clk_asic;

    dbg_uart_txq_if #(.FIFO_AW(FIFO_AW)) bus ();

    dbg_uart_txq #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk_asic (clk_asic),
        .rst_n    (rst_n),
        .bus      (bus),
        .tx       (tx)
    );

    int checks = 0;
    int errors = 0;

    // model: queue of waiting bytes, remaining cycles of the frame on the wire, its bit pattern
    logic [7:0]  q[$];
    int          busy;
    logic        ovf_m;
    logic [10:0] fbits;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       flush;
        logic       clr;
        int         lvl;
        logic       full;
        logic       ovf;
        logic       txe;
        logic       tx;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef DBG_UART_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        busy  = 0;
        ovf_m = 1'b0;
        fbits = '1;
    endtask

    task automatic model_edge(input logic w, input logic [7:0] d, input logic f, input logic c);
        logic       full_m, popped;
        logic [7:0] pb;
        full_m = (q.size() == DEPTH);
        popped = 1'b0;
        pb     = 8'h00;
        if (busy <= 1 && q.size() > 0) begin
            pb     = q[0];
            popped = 1'b1;
        end
        if (f) q.delete();
        else if (popped) void'(q.pop_front());
        if (w && !full_m) q.push_back(d);
        if (w && full_m) ovf_m = 1'b1;
        else if (c) ovf_m = 1'b0;
        if (popped) begin
            busy  = FRAME;
            fbits = make_frame(pb);
        end else if (busy > 0) busy--;
    endtask

    task automatic compare_model();
        logic exp_tx;
        exp_tx = (busy > 0) ? fbits[(FRAME - busy) / CLK_DIV] : 1'b1;
        chk("m_level", int'(bus.level), q.size());
        chk("m_full",  int'(bus.full),  int'(q.size() == DEPTH));
        chk("m_txe",   int'(bus.txe),   int'(q.size() == 0 && busy == 0));
        chk("m_ovf",   int'(bus.ovf),   int'(ovf_m));
        chk("m_tx",    int'(tx),        int'(exp_tx));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic f, input logic c);
        bus.wr      = w;
        bus.data    = d;
        bus.flush   = f;
        bus.ovf_clr = c;
        @(posedge clk_asic);
        model_edge(w, d, f, c);
        @(negedge clk_asic);
        compare_model();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.txe !== 1'b1 && n < budget) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("drain_timeout", int'(bus.txe), 1);
    endtask

    task automatic frame_test(input logic [7:0] b);
        logic [10:0] pat;
        pat = make_frame(b);
        step(1'b1, b, 1'b0, 1'b0);
        chk("lat_txe_low", int'(bus.txe), 0);
        chk("lat_tx_high", int'(tx), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            chk("frame_bit", int'(tx), int'(pat[i / CLK_DIV]));
            chk("frame_txe", int'(bus.txe), 0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        chk("frame_end_txe", int'(bus.txe), 1);
        chk("frame_end_tx", int'(tx), 1);
    endtask

    initial begin
        int s;
        int wr_pct;
        logic w, f, c;

        // cycle-by-cycle from idle: fill, overflow, clear races, flush, flush+write
        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'h07, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h08, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h09, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};

        bus.wr = 1'b0; bus.data = 8'h00; bus.flush = 1'b0; bus.ovf_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_asic);
        chk("rst_tx", int'(tx), 1);
        chk("rst_txe", int'(bus.txe), 1);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        frame_test(8'hA5);
        frame_test(8'h07);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].wr, tbl[i].data, tbl[i].flush, tbl[i].clr);
            chk("tbl_level", int'(bus.level), tbl[i].lvl);
            chk("tbl_full", int'(bus.full), int'(tbl[i].full));
            chk("tbl_ovf", int'(bus.ovf), int'(tbl[i].ovf));
            chk("tbl_txe", int'(bus.txe), int'(tbl[i].txe));
            chk("tbl_tx", int'(tx), int'(tbl[i].tx));
        end
        wait_idle(8 * FRAME);

        // five back-to-back bytes: no drop, frames contiguous
        s = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            s++;
        end
        chk("b2b_ovf", int'(bus.ovf), 0);
        chk("b2b_level", int'(bus.level), 4);
        while (bus.txe !== 1'b1 && s < 8 * FRAME) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            s++;
        end
        chk("b2b_txe_cycle", s, 5 * FRAME + 2);

        // flush during the first of three frames
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        s = 3;
        repeat (5) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            s++;
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        s++;
        chk("flush_level", int'(bus.level), 0);
        chk("flush_txe", int'(bus.txe), 0);
        while (bus.txe !== 1'b1 && s < 4 * FRAME) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            s++;
        end
        chk("flush_txe_cycle", s, FRAME + 2);

        wr_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) wr_pct = int'($urandom_range(5, 90));
            w = (int'($urandom_range(0, 99)) < wr_pct);
            f = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 19) == 0);
            if (f && q.size() == DEPTH) w = 1'b0;
            step(w, 8'($urandom), f, c);
        end
        wait_idle(8 * FRAME);

        // async reset in the middle of a frame with a sticky overflow pending
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("pre_rst_ovf", int'(bus.ovf), 1);
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk_asic);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_tx", int'(tx), 1);
        chk("async_txe", int'(bus.txe), 1);
        chk("async_level", int'(bus.level), 0);
        chk("async_full", int'(bus.full), 0);
        chk("async_ovf", int'(bus.ovf), 0);
        model_reset();
        @(negedge clk_asic);
        @(negedge clk_asic);
        rst_n = 1'b1;
        repeat (12) step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
